// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data, memory and pipeline-control signals around the
// unified-memory arbiter. The slave view belongs to the arbiter itself.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_mask;
  logic [31:0] d_rdata;
  logic        d_valid;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        flush;
  logic        stall_IF;
  logic        stall_MW;
  logic        err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_mask,
           mem_ready, mem_rdata, flush,
    output if_rdata, if_valid, d_rdata, d_valid,
           mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
           stall_IF, stall_MW, err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_mask,
           mem_ready, mem_rdata, flush,
    input  if_rdata, if_valid, d_rdata, d_valid,
           mem_req, mem_we, mem_addr, mem_wdata, mem_mask,
           stall_IF, stall_MW, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and the MW stage:
// data-first with a starvation limit, flush-kill of fetches, access timeout.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input logic             clk,
  input logic             rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] starve_cnt;
  logic [7:0] wait_cnt;
  logic       kill;
  logic       grant_d, grant_f, done, expire;

  assign bus.stall_IF = bus.if_req & ~bus.if_valid;
  assign bus.stall_MW = bus.d_req  & ~bus.d_valid;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant_d = 1'b0;
    grant_f = 1'b0;
    done    = 1'b0;
    expire  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A requester still seeing its valid pulse has not yet dropped req.
        if (!(bus.if_valid || bus.d_valid)) begin
          if (bus.d_req && !(bus.if_req && starve_cnt == STARVE_LIM)) begin
            grant_d = 1'b1;
            state_d = DATA;
          end else if (bus.if_req) begin
            grant_f = 1'b1;
            state_d = FETCH;
          end
        end
      end
      FETCH, DATA: begin
        if (bus.mem_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          expire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_mask  <= '0;
      bus.if_rdata  <= '0;
      bus.if_valid  <= 1'b0;
      bus.d_rdata   <= '0;
      bus.d_valid   <= 1'b0;
      bus.err       <= 1'b0;
      starve_cnt    <= '0;
      wait_cnt      <= '0;
      kill          <= 1'b0;
    end else begin
      bus.if_valid <= 1'b0;
      bus.d_valid  <= 1'b0;
      bus.err      <= expire;

      if (grant_d) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= bus.d_we;
        bus.mem_addr  <= bus.d_addr;
        bus.mem_wdata <= bus.d_wdata;
        bus.mem_mask  <= bus.d_mask;
        wait_cnt      <= '0;
        if (bus.if_req && starve_cnt < STARVE_LIM)
          starve_cnt <= starve_cnt + 8'd1;
      end

      if (grant_f) begin
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= 1'b0;
        bus.mem_addr  <= bus.if_addr;
        bus.mem_wdata <= '0;
        bus.mem_mask  <= '0;
        wait_cnt      <= '0;
        kill          <= 1'b0;
        starve_cnt    <= '0;
      end

      if (state_q != IDLE && !bus.mem_ready)
        wait_cnt <= wait_cnt + 8'd1;

      if (state_q == FETCH && bus.flush)
        kill <= 1'b1;

      // Timeout completes the owner like a normal access but with zero data.
      if (done || expire) begin
        bus.mem_req <= 1'b0;
        if (state_q == FETCH) begin
          if (!kill && !bus.flush) begin
            bus.if_valid <= 1'b1;
            bus.if_rdata <= done ? bus.mem_rdata : '0;
          end
        end else begin
          bus.d_valid <= 1'b1;
          if (!bus.mem_we)
            bus.d_rdata <= done ? bus.mem_rdata : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-programmable memory
// responder; every expectation is a hand-derived cycle-exact constant.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   lat    = 1;
  int   rcnt   = 0;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .STARVE_MAX(4),
    .TIMEOUT   (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
  endfunction

  // Memory answers in the lat-th cycle of mem_req; lat == 0 never answers.
  always @(posedge clk) begin
    if (!bus.mem_req || bus.mem_ready) rcnt <= 0;
    else                               rcnt <= rcnt + 1;
  end
  assign bus.mem_ready = bus.mem_req && (lat > 0) && (rcnt == lat - 1);
  assign bus.mem_rdata = bus.mem_ready ? rd(bus.mem_addr) : 32'hDEAD_DEAD;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [10:0] mr, iv, ev, dv;
  logic [5:0]  order;
  int          grants;
  logic        prev_req;
  logic        found;

  initial begin
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0;
    bus.d_wdata = '0; bus.d_mask = '0; bus.flush = 1'b0;
    tick(); tick();
    check("rst_mem_req",  32'(bus.mem_req), 0);
    check("rst_valids",   32'({bus.if_valid, bus.d_valid, bus.err, bus.mem_we}), 0);
    check("rst_buses",    bus.mem_addr | bus.mem_wdata | 32'(bus.mem_mask) | bus.if_rdata | bus.d_rdata, 0);
    check("rst_state",    32'(dut.state_q), 0);
    rst = 1'b0;
    tick();

    // Fetch only, single-cycle memory
    lat = 1; bus.if_req = 1'b1; bus.if_addr = 32'h100; #1;
    check("f_stall_c0", 32'(bus.stall_IF), 1);
    tick();
    check("f_req_c1",   32'(bus.mem_req), 1);
    check("f_mask_c1",  32'(bus.mem_mask), 0);
    check("f_addr_c1",  bus.mem_addr, 32'h100);
    check("f_stall_c1", 32'(bus.stall_IF), 1);
    tick();
    check("f_valid_c2", 32'(bus.if_valid), 1);
    check("f_rdata_c2", bus.if_rdata, 32'h0050_0093);
    check("f_stall_c2", 32'(bus.stall_IF), 0);
    bus.if_req = 1'b0;
    tick();
    check("f_valid_c3", 32'(bus.if_valid), 0);

    // Simultaneous fetch and load: data first, then fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h104;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200; bus.d_mask = 4'hF;
    tick();
    check("b_addr_c1",  bus.mem_addr, 32'h200);
    check("b_starve1",  32'(dut.starve_cnt), 1);
    tick();
    check("b_dvalid",   32'(bus.d_valid), 1);
    check("b_drdata",   bus.d_rdata, rd(32'h200));
    check("b_stallmw",  32'(bus.stall_MW), 0);
    bus.d_req = 1'b0;
    tick();
    check("b_idle_c3",  32'(bus.mem_req), 0);
    tick();
    check("b_faddr_c4", bus.mem_addr, 32'h104);
    check("b_starve0",  32'(dut.starve_cnt), 0);
    tick();
    check("b_ivalid",   32'(bus.if_valid), 1);
    check("b_irdata",   bus.if_rdata, rd(32'h104));
    bus.if_req = 1'b0;
    tick();

    // Starvation limit: D D D D F D
    bus.if_req = 1'b1; bus.if_addr = 32'h108;
    bus.d_req = 1'b1; bus.d_addr = 32'h300;
    order = '0; grants = 0; prev_req = 1'b0;
    for (int c = 0; c < 40 && grants < 6; c++) begin
      tick();
      if (bus.mem_req && !prev_req) begin
        order = {order[4:0], (bus.mem_addr == 32'h300)};
        grants++;
      end
      prev_req = bus.mem_req;
    end
    check("s_grants",  32'(grants), 6);
    check("s_order",   32'(order), 32'b111101);
    check("s_starve",  32'(dut.starve_cnt), 1);
    tick();
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    tick(); tick();

    // Flush during fetch, then re-issue
    lat = 3; bus.if_req = 1'b1; bus.if_addr = 32'h10C;
    mr = '0; iv = '0;
    for (int n = 1; n <= 9; n++) begin
      tick();
      bus.flush = (n == 1);
      mr[n] = bus.mem_req;
      iv[n] = bus.if_valid;
      if (n == 8) begin
        check("k_rdata", bus.if_rdata, rd(32'h10C));
        bus.if_req = 1'b0;
      end
    end
    check("k_mem_req", 32'(mr), 32'b0_0011101110);
    check("k_ivalid",  32'(iv), 32'b0_0100000000);
    tick();

    // Normal store: d_rdata keeps the last load value
    lat = 2;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h500;
    bus.d_wdata = 32'h1234_5678; bus.d_mask = 4'b1000;
    tick();
    check("w_we",    32'(bus.mem_we), 1);
    check("w_mask",  32'(bus.mem_mask), 32'h8);
    check("w_wdata", bus.mem_wdata, 32'h1234_5678);
    tick(); tick();
    check("w_dvalid", 32'(bus.d_valid), 1);
    check("w_rdata",  bus.d_rdata, rd(32'h300));
    bus.d_req = 1'b0;
    tick();

    // Store that never completes: timeout after TIMEOUT cycles
    lat = 0;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h400;
    bus.d_wdata = 32'hCAFE_F00D; bus.d_mask = 4'b0011;
    mr = '0; ev = '0; dv = '0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      mr[n] = bus.mem_req; ev[n] = bus.err; dv[n] = bus.d_valid;
      if (n == 1) check("t_addr", bus.mem_addr, 32'h400);
      if (n == 9) begin
        check("t_stallmw", 32'(bus.stall_MW), 0);
        bus.d_req = 1'b0;
      end
    end
    check("t_mem_req", 32'(mr), 32'b00111111110);
    check("t_err",     32'(ev), 32'b01000000000);
    check("t_dvalid",  32'(dv), 32'b01000000000);
    check("t_state",   32'(dut.state_q), 0);

    // Reset in the middle of a data access with starve_cnt saturated
    lat = 1; bus.d_we = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h108;
    bus.d_req = 1'b1; bus.d_addr = 32'h300;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      tick();
      if (bus.mem_req && dut.starve_cnt == 8'd4) found = 1'b1;
    end
    check("r_found", 32'(found), 1);
    lat = 0; rst = 1'b1;
    tick();
    check("r_mem_req", 32'(bus.mem_req), 0);
    check("r_valids",  32'({bus.if_valid, bus.d_valid, bus.err}), 0);
    check("r_state",   32'(dut.state_q), 0);
    rst = 1'b0; lat = 1;
    tick();
    check("r_regrant_d", bus.mem_addr, 32'h300);
    check("r_regrant_rq", 32'(bus.mem_req), 1);
    tick();
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-port unified memory between the instruction-fetch stage and the memory/writeback (MW) stage of the 3-stage RISC-V pipeline. It grants one requester at a time, data before fetch, with a starvation limit that guarantees fetch progress. It holds a request/ready handshake toward variable-latency memory and drives per-stage stall outputs that the hazard logic merges with its own stall/flush terms. A branch flush cancels an in-flight fetch, and a timeout converts a hung access into an error pulse.

## Interface
- STARVE_MAX, 4: consecutive data grants allowed while a fetch is pending; range 1..255.
- TIMEOUT, 64: cycles `mem_req` may remain high without `mem_ready` before the access is aborted; range 2..255.
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- if_req  input  1  fetch request; held until `if_valid`.
- if_addr  input  32  fetch address.
- if_rdata  output  32  fetched instruction; valid while `if_valid` is high.
- if_valid  output  1  one-cycle fetch completion pulse.
- d_req  input  1  data request from the MW stage; held until `d_valid`.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  32  data address.
- d_wdata  input  32  store data.
- d_mask  input  4  store byte enables.
- d_rdata  output  32  load data; holds its previous value after a store.
- d_valid  output  1  one-cycle data completion pulse, for both loads and stores.
- mem_req  output  1  memory request.
- mem_we  output  1  memory write enable.
- mem_addr  output  32  memory address.
- mem_wdata  output  32  memory write data.
- mem_mask  output  4  memory byte enables; 4'b0000 on fetches.
- mem_ready  input  1  access complete; `mem_rdata` is valid in the same cycle.
- mem_rdata  input  32  memory read data.
- flush  input  1  branch taken; kills the current fetch.
- stall_IF  output  1  `if_req & ~if_valid`, combinational.
- stall_MW  output  1  `d_req & ~d_valid`, combinational.
- err  output  1  one-cycle pulse when an access is aborted by timeout.

## Operation
- Reset values:
  - State IDLE.
  - Outputs `mem_req`, `mem_we`, `if_valid`, `d_valid` and `err` are 0.
  - Buses `if_rdata`, `d_rdata`, `mem_addr`, `mem_wdata` and `mem_mask` are 0.
  - Counters `starve_cnt` and `wait_cnt` are 0; `kill` is 0.
- FSM states: IDLE, FETCH, DATA.
- IDLE:
  - No grant is made in any cycle where `if_valid` or `d_valid` is high; those requests are stale.
  - Otherwise, if `d_req` and not (`if_req` and `starve_cnt == STARVE_MAX`), go to DATA.
  - Otherwise, if `if_req`, go to FETCH.
  - Otherwise, stay in IDLE.
- Grant edge:
  - Register the request fields into `mem_addr`, `mem_we`, `mem_wdata` and `mem_mask`.
  - Set `mem_req` = 1 and clear `wait_cnt`.
  - A FETCH grant also clears `kill`.
- `starve_cnt` update:
  - A DATA grant taken while `if_req` is high increments `starve_cnt`, saturating at STARVE_MAX.
  - A FETCH grant clears `starve_cnt`.
  - A DATA grant taken while `if_req` is low leaves `starve_cnt` unchanged.
- FETCH and DATA:
  - `mem_*` outputs stay stable until `mem_ready`.
  - `wait_cnt` increments on every cycle `mem_ready` is low.
- On `mem_ready`:
  - Drop `mem_req` and return to IDLE.
  - From FETCH: register `if_rdata` and pulse `if_valid`, unless `kill` is set or `flush` is high in the same cycle. A killed fetch gets no pulse; the requester re-issues it.
  - From DATA: pulse `d_valid`. On a load, also register `mem_rdata` into `d_rdata`.
- `flush`:
  - In FETCH it sets `kill`.
  - In IDLE or DATA it has no effect.
  - It never aborts a memory transaction already in progress.
- Timeout: when `wait_cnt == TIMEOUT-1` and `mem_ready` is low:
  - Drop `mem_req`, pulse `err`, and return to IDLE.
  - Pulse the owner's valid with rdata = 0; a killed fetch gets no pulse.
  - The pipeline therefore never hangs.
- `rst` mid-access: the request is abandoned immediately and all reset values apply on the next cycle.

## Timing
- Cycle 0: IDLE sees the request. Cycle 1: `mem_req` is high.
- `mem_ready` at cycle k (k ≥ 1) gives valid/rdata at cycle k+1.
- Minimum round trip is 2 cycles. The next grant decision is at cycle k+2.
- Back-to-back accesses are therefore spaced at least 3 cycles apart.
- `stall_IF` and `stall_MW` are combinational, so they deassert in the same cycle as the valid pulse.
- `err` coincides with the aborting valid pulse, at cycle TIMEOUT+1 after the grant cycle.

## Test plan
- Fetch only, `mem_ready` one cycle after `mem_req`, `if_addr` = 0x100, `mem_rdata` = 0x00500093:
  - `mem_req` at cycle 1, `mem_mask` = 0.
  - `if_valid` at cycle 2 with `if_rdata` = 0x00500093; `stall_IF` is high in cycles 0-1.
- `if_req` and `d_req` together, `d_we` = 0, `d_addr` = 0x200:
  - DATA is granted first; `d_valid` arrives, then FETCH is granted.
  - `starve_cnt` = 1 after the DATA grant, then 0 after the FETCH grant.
- `d_req` held continuously (5 loads) with `if_req` high, STARVE_MAX = 4:
  - Grant order is D, D, D, D, F, D.
- Flush during FETCH, with `mem_ready` 3 cycles later:
  - `if_valid` is never pulsed and `mem_req` completes normally.
  - A re-issued fetch then completes with `if_valid`.
- `mem_ready` never asserted on a store, TIMEOUT = 8:
  - `mem_req` stays high for cycles 1-8.
  - `err` and `d_valid` pulse at cycle 9, then the FSM returns to IDLE.
- `rst` asserted during DATA with `mem_req` high:
  - The next cycle has `mem_req` = 0, all valids = 0, state IDLE.
  - The `starve_cnt` value reached before reset does not affect arbitration after release.
